core_scheduler: RTL and testbench
=================================

# core_scheduler

Per-core control sequencer that steps one block of threads through the instruction pipeline and broadcasts `core_state` to the per-thread PC, ALU, LSU and register stages. It gates progress on the fetcher and the per-thread LSUs. In UPDATE it collects the per-thread `next_pc` values produced during EXECUTE and commits the shared `current_pc`. It also detects branch divergence across enabled threads and raises `done` on RET.

## Interface
Parameters:
- `THREADS_PER_BLOCK`, default 4: number of thread lanes in the core.
- `PROGRAM_MEM_ADDR_BITS`, default 8: width of the PC.

Ports:
- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin executing the block from PC 0.
- `thread_count`, in, $clog2(THREADS_PER_BLOCK)+1: number of active lanes; latched on accepted `start`.
- `decoded_ret`, in, 1: the current instruction is RET.
- `fetcher_state`, in, 3: fetcher FSM state; FETCHED = 3'b010.
- `lsu_state`, in, THREADS_PER_BLOCK*2: per-lane LSU state. Lane i occupies bits [2i+1:2i]. IDLE=00, REQUESTING=01, WAITING=10, DONE=11.
- `next_pc`, in, THREADS_PER_BLOCK*PROGRAM_MEM_ADDR_BITS: per-lane next PC, packed the same way.
- `core_state`, out, 3: pipeline state broadcast.
- `current_pc`, out, PROGRAM_MEM_ADDR_BITS: shared PC.
- `thread_enable`, out, THREADS_PER_BLOCK: bit i = (i < latched thread_count).
- `diverged`, out, 1: sticky divergence flag.
- `done`, out, 1: the block has finished.

## Operation
State encoding: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.

Reset values: core_state=IDLE, current_pc=0, thread_enable=0, diverged=0, done=0, latched count=0.

Transitions:
- IDLE, `start`=1:
  - Latch `thread_count`; current_pc←0; diverged←0.
  - Go to FETCH, or straight to DONE if `thread_count`=0.
- FETCH: stay until `fetcher_state`=FETCHED, then go to DECODE.
- DECODE → REQUEST → WAIT: one cycle each, unconditional.
- WAIT: go to EXECUTE on the first cycle in which no enabled lane has `lsu_state` of REQUESTING or WAITING. Disabled lanes are ignored.
- EXECUTE → UPDATE: one cycle.
- UPDATE:
  - If `decoded_ret`=1: go to DONE, done←1, current_pc unchanged.
  - Otherwise: current_pc←`next_pc` of lane 0, then go to FETCH.
  - In both cases, if any enabled lane's `next_pc` differs from lane 0's, diverged←1. The flag stays set until the next accepted `start` or reset.
- DONE: hold until reset. `start` is ignored.

Further rules:
- `start` is ignored in every state except IDLE.
- `thread_count` greater than THREADS_PER_BLOCK saturates to THREADS_PER_BLOCK.
- current_pc wraps modulo 2^PROGRAM_MEM_ADDR_BITS, because it is taken from `next_pc` unmodified.

## Timing
- All outputs are registered; none is a combinational function of inputs.
- `core_state`=EXECUTE lasts exactly one cycle. Each lane's PC stage registers its `next_pc` on that edge, so `next_pc` is stable and valid throughout UPDATE, when this block samples it.
- Minimum instruction latency is 6 cycles (FETCH with FETCHED already present, plus WAIT with no memory op).
- `done` rises on the edge that enters DONE.
- current_pc changes only on the UPDATE→FETCH edge, and on the IDLE→FETCH edge (to 0).
- Reset asserted in any state returns every output to its reset value immediately, without waiting for a clock edge. Operation resumes only through IDLE plus a new `start`.

## Structure
- Shared package `gpu_pkg` holds:
  - the `core_state_t` enum with the encodings above;
  - the `FETCHER_FETCHED` constant;
  - the LSU state constants.

  The PC, ALU, LSU and fetcher stages already decode `core_state` and import the same package.
- One natural sub-module, `lane_pc_agree`: combinational. It takes the packed `next_pc`, `thread_enable` and lane 0's PC, and outputs `mismatch`.
- The FSM, PC register and flags live in `core_scheduler`.

## Test plan
- Straight-line program, 4 lanes, all `next_pc`=current_pc+1, FETCHED on the first FETCH cycle, RET at PC 3:
  - current_pc sequences 0,1,2,3;
  - each instruction takes 6 cycles;
  - `done`=1 after 24 cycles;
  - diverged=0.
- Memory stall: lane 2 LSU holds WAITING for 5 cycles in WAIT → WAIT lasts 5 cycles, then EXECUTE. With `thread_count`=2 the same stall on lane 2 → no stall.
- Branch: in UPDATE, lanes 0–3 present `next_pc`=8'h0A → current_pc=8'h0A. If lane 3 presents 8'h05 instead → current_pc=8'h0A and diverged=1, sticky through later instructions.
- Wrap: `next_pc`=8'h00 in UPDATE from current_pc 8'hFF → current_pc=0, no error.
- Reset asserted mid-WAIT, between clock edges → outputs return to their reset values at once. A later `start` restarts at PC 0.
- `start` with `thread_count`=0 → DONE next cycle, thread_enable=0. A `start` pulse while in FETCH → no effect.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU core definitions: pipeline state encoding plus fetcher and LSU state codes
// used by the scheduler and every per-thread stage that decodes core_state.
package gpu_pkg;

  typedef enum logic [2:0] {
    CS_IDLE    = 3'b000,
    CS_FETCH   = 3'b001,
    CS_DECODE  = 3'b010,
    CS_REQUEST = 3'b011,
    CS_WAIT    = 3'b100,
    CS_EXECUTE = 3'b101,
    CS_UPDATE  = 3'b110,
    CS_DONE    = 3'b111
  } core_state_t;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;

  localparam logic [1:0] LSU_IDLE       = 2'b00;
  localparam logic [1:0] LSU_REQUESTING = 2'b01;
  localparam logic [1:0] LSU_WAITING    = 2'b10;
  localparam logic [1:0] LSU_DONE       = 2'b11;

  // A lane holds the block in WAIT while its memory op is still outstanding.
  function automatic logic lsu_busy(input logic [1:0] s);
    return (s == LSU_REQUESTING) || (s == LSU_WAITING);
  endfunction

endpackage

// File: rtl/core_scheduler_lane_pc_agree.sv
// Combinational check that every enabled lane agrees with lane 0 on the next PC.
module lane_pc_agree
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
  input  logic [THREADS_PER_BLOCK*PROGRAM_MEM_ADDR_BITS-1:0] next_pc,
  input  logic [THREADS_PER_BLOCK-1:0]                       thread_enable,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0]                   lane0_pc,
  output logic                                               mismatch
);

  always_comb begin
    mismatch = 1'b0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      if (thread_enable[i] &&
          (next_pc[i*PROGRAM_MEM_ADDR_BITS +: PROGRAM_MEM_ADDR_BITS] != lane0_pc)) begin
        mismatch = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_scheduler.sv
// Per-core control sequencer: walks one thread block through FETCH..UPDATE,
// commits the shared PC, tracks branch divergence and flags completion on RET.
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]                 thread_count,
  input  logic                                               decoded_ret,
  input  logic [2:0]                                         fetcher_state,
  input  logic [THREADS_PER_BLOCK*2-1:0]                     lsu_state,
  input  logic [THREADS_PER_BLOCK*PROGRAM_MEM_ADDR_BITS-1:0] next_pc,
  output logic [2:0]                                         core_state,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]                   current_pc,
  output logic [THREADS_PER_BLOCK-1:0]                       thread_enable,
  output logic                                               diverged,
  output logic                                               done
);

  localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;
  localparam int PW  = PROGRAM_MEM_ADDR_BITS;

  core_state_t     state_q, state_d;
  logic [PW-1:0]   pc_q, pc_d;
  logic [TCW-1:0]  count_q, count_d;
  logic            div_q, div_d;
  logic            done_q, done_d;
  logic            any_busy;
  logic            mismatch;

  function automatic logic [TCW-1:0] sat_count(input logic [TCW-1:0] c);
    return (c > TCW'(THREADS_PER_BLOCK)) ? TCW'(THREADS_PER_BLOCK) : c;
  endfunction

  always_comb begin
    thread_enable = '0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      thread_enable[i] = (TCW'(i) < count_q);
    end
  end

  // Disabled lanes may show any LSU state; only enabled lanes can stall WAIT.
  always_comb begin
    any_busy = 1'b0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      if (thread_enable[i] && lsu_busy(lsu_state[2*i +: 2])) begin
        any_busy = 1'b1;
      end
    end
  end

  lane_pc_agree #(
    .THREADS_PER_BLOCK    (THREADS_PER_BLOCK),
    .PROGRAM_MEM_ADDR_BITS(PROGRAM_MEM_ADDR_BITS)
  ) u_agree (
    .next_pc      (next_pc),
    .thread_enable(thread_enable),
    .lane0_pc     (next_pc[PW-1:0]),
    .mismatch     (mismatch)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    div_d   = div_q;
    done_d  = done_q;
    case (state_q)
      CS_IDLE: begin
        if (start) begin
          count_d = sat_count(thread_count);
          pc_d    = '0;
          div_d   = 1'b0;
          if (thread_count == '0) begin
            state_d = CS_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = CS_FETCH;
          end
        end
      end
      CS_FETCH: begin
        if (fetcher_state == FETCHER_FETCHED) state_d = CS_DECODE;
      end
      CS_DECODE:  state_d = CS_REQUEST;
      CS_REQUEST: state_d = CS_WAIT;
      CS_WAIT: begin
        if (!any_busy) state_d = CS_EXECUTE;
      end
      CS_EXECUTE: state_d = CS_UPDATE;
      CS_UPDATE: begin
        if (mismatch) div_d = 1'b1;
        if (decoded_ret) begin
          state_d = CS_DONE;
          done_d  = 1'b1;
        end else begin
          pc_d    = next_pc[PW-1:0];
          state_d = CS_FETCH;
        end
      end
      CS_DONE: state_d = CS_DONE;
      default: state_d = CS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CS_IDLE;
      pc_q    <= '0;
      count_q <= '0;
      div_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      div_q   <= div_d;
      done_q  <= done_d;
    end
  end

  assign core_state = state_q;
  assign current_pc = pc_q;
  assign diverged   = div_q;
  assign done       = done_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Bench for core_scheduler: table of directed instructions, hand-written corner
// sequences, then randomized blocks checked against a per-instruction timing model.
module tb_core_scheduler;
  import gpu_pkg::*;

  localparam int T   = 4;
  localparam int W   = 8;
  localparam int TCW = $clog2(T) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [TCW-1:0]   thread_count;
  logic             decoded_ret;
  logic [2:0]       fetcher_state;
  logic [2*T-1:0]   lsu_state;
  logic [T*W-1:0]   next_pc;
  logic [2:0]       core_state;
  logic [W-1:0]     current_pc;
  logic [T-1:0]     thread_enable;
  logic             diverged;
  logic             done;

  int n_vec = 0;
  int n_bad = 0;

  int         cur_fdel;
  int         cur_stall [T];
  logic [W-1:0] cur_npc [T];
  logic       cur_ret;

  typedef struct packed {
    logic             new_blk;
    logic [3:0]       tc;
    logic [3:0]       fdel;
    logic [T-1:0][3:0] stall;
    logic [T-1:0][W-1:0] npc;
    logic             ret;
    logic [7:0]       e_cyc;
    logic [W-1:0]     e_pc;
    logic             e_div;
    logic             e_done;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  core_scheduler #(.THREADS_PER_BLOCK(T), .PROGRAM_MEM_ADDR_BITS(W)) dut (
    .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
    .decoded_ret(decoded_ret), .fetcher_state(fetcher_state), .lsu_state(lsu_state),
    .next_pc(next_pc), .core_state(core_state), .current_pc(current_pc),
    .thread_enable(thread_enable), .diverged(diverged), .done(done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input bit nb, input int tc, input int fd, input logic [15:0] st,
                              input logic [31:0] np, input bit rt, input int ec, input int ep,
                              input bit ed, input bit edn);
    vec_t v;
    v.new_blk = nb;      v.tc = 4'(tc);   v.fdel = 4'(fd);
    v.stall = st;        v.npc = np;      v.ret = rt;
    v.e_cyc = 8'(ec);    v.e_pc = W'(ep); v.e_div = ed; v.e_done = edn;
    return v;
  endfunction

  function automatic int en_mask(input int tc);
    int en = (tc > T) ? T : tc;
    return (1 << en) - 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic begin_block(input int tc);
    thread_count = TCW'(tc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Acts as fetcher/LSUs/PC stages for one instruction, then checks its outcome.
  task automatic run_inst(input int e_cyc, input int e_pc, input bit e_div, input bit e_done);
    int cyc = 0, fcnt = 0, wcnt = 0;
    bit left = 0, pc_moved = 0;
    logic [2:0] prev;
    logic [W-1:0] pc0 = current_pc;
    while (!left && cyc < 300) begin
      if (core_state == 3'(CS_FETCH)) fcnt++;
      if (core_state == 3'(CS_WAIT))  wcnt++;
      fetcher_state = (core_state == 3'(CS_FETCH) && fcnt >= cur_fdel) ? FETCHER_FETCHED : 3'b000;
      for (int i = 0; i < T; i++) begin
        lsu_state[2*i +: 2] = (core_state == 3'(CS_WAIT) && wcnt < cur_stall[i]) ? LSU_WAITING :
                              ((i % 2 == 1) ? LSU_DONE : LSU_IDLE);
        next_pc[i*W +: W] = cur_npc[i];
      end
      decoded_ret = cur_ret;
      prev = core_state;
      @(negedge clk);
      cyc++;
      if (prev == 3'(CS_UPDATE)) left = 1;
      else if (current_pc !== pc0) pc_moved = 1;
    end
    if (!left) begin
      chk("instr_timeout", 32'(cyc), 32'(e_cyc));
    end else begin
      chk("instr_cycles", 32'(cyc), 32'(e_cyc));
      chk("pc", 32'(current_pc), 32'(e_pc));
      chk("pc_stable_in_instr", 32'(pc_moved), 32'd0);
      chk("diverged", 32'(diverged), 32'(e_div));
      chk("done", 32'(done), 32'(e_done));
      chk("state_after_update", 32'(core_state), e_done ? 32'(CS_DONE) : 32'(CS_FETCH));
    end
  endtask

  initial begin
    int tc, en, n, wmax, mpc;
    bit mdiv;
    logic [W-1:0] base;

    reset = 1'b1; start = 1'b0; thread_count = '0; decoded_ret = 1'b0;
    fetcher_state = 3'b000; lsu_state = '0; next_pc = '0;
    #3;
    chk("reset_state", 32'(core_state), 32'(CS_IDLE));
    chk("reset_pc", 32'(current_pc), 32'd0);
    chk("reset_enable", 32'(thread_enable), 32'd0);
    chk("reset_div_done", 32'({diverged, done}), 32'd0);

    // straight-line, stall, branch/divergence, wrap, small block, saturated count
    tbl[0]  = mk(1, 4, 1, 16'h0000, 32'h01010101, 0, 6, 8'h01, 0, 0);
    tbl[1]  = mk(0, 4, 1, 16'h0000, 32'h02020202, 0, 6, 8'h02, 0, 0);
    tbl[2]  = mk(0, 4, 1, 16'h0000, 32'h03030303, 0, 6, 8'h03, 0, 0);
    tbl[3]  = mk(0, 4, 1, 16'h0000, 32'h04040404, 1, 6, 8'h03, 0, 1);
    tbl[4]  = mk(1, 4, 1, 16'h0500, 32'h0A0A0A0A, 0, 10, 8'h0A, 0, 0);
    tbl[5]  = mk(0, 4, 3, 16'h0000, 32'h050B0B0B, 0, 8, 8'h0B, 1, 0);
    tbl[6]  = mk(0, 4, 1, 16'h0000, 32'hFFFFFFFF, 0, 6, 8'hFF, 1, 0);
    tbl[7]  = mk(0, 4, 1, 16'h0000, 32'h00000000, 0, 6, 8'h00, 1, 0);
    tbl[8]  = mk(0, 4, 1, 16'h0000, 32'h01010101, 1, 6, 8'h00, 1, 1);
    tbl[9]  = mk(1, 2, 1, 16'h5500, 32'h33330707, 0, 6, 8'h07, 0, 0);
    tbl[10] = mk(0, 2, 2, 16'h0030, 32'h00000909, 0, 9, 8'h09, 0, 0);
    tbl[11] = mk(0, 2, 1, 16'h0000, 32'h00000A0B, 1, 6, 8'h09, 1, 1);
    tbl[12] = mk(1, 7, 1, 16'h2000, 32'h11111111, 0, 7, 8'h11, 0, 0);
    tbl[13] = mk(0, 7, 1, 16'h0000, 32'h22222222, 1, 6, 8'h11, 0, 1);

    for (int v = 0; v < NV; v++) begin
      if (tbl[v].new_blk) begin
        do_reset();
        begin_block(int'(tbl[v].tc));
        chk("start_enable", 32'(thread_enable), 32'(en_mask(int'(tbl[v].tc))));
        chk("start_pc", 32'(current_pc), 32'd0);
      end
      cur_fdel = int'(tbl[v].fdel);
      for (int i = 0; i < T; i++) begin
        cur_stall[i] = int'(tbl[v].stall[i]);
        cur_npc[i]   = tbl[v].npc[i];
      end
      cur_ret = tbl[v].ret;
      run_inst(int'(tbl[v].e_cyc), int'(tbl[v].e_pc), tbl[v].e_div, tbl[v].e_done);
    end

    // thread_count = 0 goes straight to DONE; start in DONE is ignored
    do_reset();
    begin_block(0);
    chk("tc0_state", 32'(core_state), 32'(CS_DONE));
    chk("tc0_done", 32'(done), 32'd1);
    chk("tc0_enable", 32'(thread_enable), 32'd0);
    begin_block(4);
    chk("start_in_done_state", 32'(core_state), 32'(CS_DONE));
    chk("start_in_done_enable", 32'(thread_enable), 32'd0);

    // start pulse during FETCH must not relatch the lane count
    do_reset();
    fetcher_state = 3'b000;
    begin_block(2);
    begin_block(4);
    chk("start_in_fetch_state", 32'(core_state), 32'(CS_FETCH));
    chk("start_in_fetch_enable", 32'(thread_enable), 32'h3);

    // asynchronous reset between edges while stalled in WAIT
    do_reset();
    fetcher_state = FETCHER_FETCHED;
    lsu_state = {T{LSU_WAITING}};
    begin_block(4);
    for (int c = 0; c < 20 && core_state != 3'(CS_WAIT); c++) @(negedge clk);
    chk("reached_wait", 32'(core_state), 32'(CS_WAIT));
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_state", 32'(core_state), 32'(CS_IDLE));
    chk("async_rst_enable", 32'(thread_enable), 32'd0);
    chk("async_rst_pc_div_done", 32'({current_pc, diverged, done}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    begin_block(4);
    chk("restart_pc", 32'(current_pc), 32'd0);
    cur_fdel = 1; cur_ret = 1'b0;
    for (int i = 0; i < T; i++) begin cur_stall[i] = 0; cur_npc[i] = 8'h05; end
    run_inst(6, 8'h05, 0, 0);

    // randomized blocks against an instruction-level model
    for (int s = 0; s < 8; s++) begin
      tc = $urandom_range(1, 7);
      en = (tc > T) ? T : tc;
      n  = $urandom_range(2, 7);
      do_reset();
      begin_block(tc);
      chk("rnd_enable", 32'(thread_enable), 32'(en_mask(tc)));
      mpc = 0; mdiv = 0;
      for (int k = 0; k < n; k++) begin
        cur_fdel = $urandom_range(1, 4);
        base = W'($urandom);
        for (int i = 0; i < T; i++) begin
          cur_stall[i] = $urandom_range(0, 6);
          cur_npc[i]   = ($urandom_range(0, 3) == 0) ? W'($urandom) : base;
        end
        cur_ret = (k == n - 1);
        wmax = 1;
        for (int i = 0; i < en; i++) begin
          if (cur_stall[i] > wmax) wmax = cur_stall[i];
          if (cur_npc[i] != cur_npc[0]) mdiv = 1;
        end
        if (!cur_ret) mpc = int'(cur_npc[0]);
        run_inst(cur_fdel + wmax + 4, mpc, mdiv, cur_ret);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
